divider_datapath: RTL and testbench
===================================

Name: divider_datapath

Overview:
- Unsigned 32-bit non-restoring division datapath, the execute end of the control-word interface driven by `control_unit_sub`.
- Consumes strobes c0..c6 and returns status `s` (partial-remainder sign) and `count31` (last iteration) to the control unit.
- Presents remainder, then quotient, on a shared registered `outbus`.
- Sits beside the control unit inside the ALU; adds no sequencing of its own beyond the strobes it receives.

Parameters:
- WIDTH, 32, operand/quotient/remainder width. A register is WIDTH+1 bits.
- CNT_W, 5, iteration counter width (clog2(WIDTH)). `count31` asserts at count == WIDTH-1.

Ports:
- clk  input  1  clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- c0  input  1  load operands, clear A and counter
- c1  input  1  shift A:Q left by one
- c2  input  1  A <= A ± M (direction set by c3)
- c3  input  1  with c2: 1 = subtract M, 0 = add M
- c4  input  1  Q[0] <= ~s; counter++
- c5  input  1  outbus <= A[WIDTH-1:0] (remainder)
- c6  input  1  outbus <= Q (quotient)
- dividend  input  WIDTH  sampled on c0
- divisor  input  WIDTH  sampled on c0
- s  output  1  A[WIDTH] (sign of partial remainder), combinational from register
- count31  output  1  counter == WIDTH-1, combinational from register
- outbus  output  WIDTH  registered result bus

Behaviour:
- Reset (async, rst_b=0) clears A (WIDTH+1), Q, M, counter and outbus to 0. This gives s=0, count31=0. Reset mid-operation abandons the division with no residue.
- All register updates happen on the rising clk edge. No strobe means hold.
- c0 loads: A<=0, Q<=dividend, M<=divisor, cnt<=0. c0 has highest priority; all other strobes in the same cycle are ignored. c0 during a division restarts it.
- c1 (shift): {A,Q} <= {A[WIDTH-1:0],Q,1'b0}. If c1 and c2 coincide, c1 wins and c2 is ignored (never issued legally).
- c2 & c3: A <= A - {1'b0,M}. c2 & ~c3: A <= A + {1'b0,M}. Arithmetic is WIDTH+1 bits, modulo 2^(WIDTH+1).
- c4: Q[0] <= ~A[WIDTH] using the pre-edge A; cnt <= cnt+1, wrapping at 2^CNT_W.
- c4 and c2 together (final correction cycle): Q[0] takes the sign before the add, while A gets the add result in the same edge.
- Iteration protocol seen from the datapath:
  - sign test on the pre-shift A;
  - shift;
  - subtract if s was 0, add if s was 1;
  - c4 sets the quotient bit.
  - 32 iterations (cnt 0..31). On the last iteration, c4+c2(add) restores a negative remainder.
- c5: outbus <= A[WIDTH-1:0]. c6: outbus <= Q. If both are asserted, c6 wins. outbus holds its value otherwise.
- Latency: the remainder is on outbus one cycle after c5; the quotient one cycle after c6.
- Results are valid only for a full c0-initiated sequence. Partial sequences leave outbus unchanged until c5/c6.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- When defined:
  - c0 latches a sticky dz flag = (divisor == 0), cleared by reset or the next c0.
  - While dz is set, c5 drives outbus = dividend latched at c0 (held in Q's shadow) and c6 drives outbus = all-ones.
  - Output port `dz` (1 bit) is added.
- When undefined: no dz logic and no dz port. Divide-by-zero yields whatever the algorithm produces (Q = all-ones, R = dividend for this algorithm).

Decomposition:
- Package div_pkg holds:
  - WIDTH / CNT_W defaults;
  - localparams naming control-bit roles (LOAD, SHIFT, ADDSUB, SUBSEL, QSET, OUT_R, OUT_Q);
  - the A-register width constant (WIDTH+1).
- One sub-module, div_addsub: (WIDTH+1)-bit adder/subtractor, inputs a, b, sub; output sum. Combinational, instantiated once.

Test Plan:
- 100 / 7 with the full control-unit strobe sequence: after c5, outbus=2; after c6, outbus=14.
- 7 / 100: remainder 7, quotient 0. s=1 after the last iteration triggers the correction add (c4+c2 same cycle) and Q[0]=0.
- 0xFFFFFFFF / 1: remainder 0, quotient 0xFFFFFFFF. count31 rises exactly in the 32nd c4 cycle.
- 37 / 37: remainder 0, quotient 1. Then c0 with 10/3 mid-way through 5 iterations: restart yields R=1, Q=3.
- Assert rst_b=0 at iteration 12: A, Q, M, cnt and outbus read 0 asynchronously, and s=0 and count31=0. A fresh 9/2 then gives R=1, Q=4.
- With DIV_ZERO_DETECT_EN, 55/0: dz=1, c5 gives outbus=55, c6 gives 0xFFFFFFFF. Next c0 with 55/5 gives dz=0, R=0, Q=11.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths and control-strobe bit roles for the divider datapath.
package div_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam int AW    = WIDTH + 1;

  // Bit positions of c0..c6 when the strobes are packed into a control word
  localparam int LOAD   = 0;
  localparam int SHIFT  = 1;
  localparam int ADDSUB = 2;
  localparam int SUBSEL = 3;
  localparam int QSET   = 4;
  localparam int OUT_R  = 5;
  localparam int OUT_Q  = 6;
  localparam int NCTL   = 7;
endpackage

// File: rtl/divider_datapath_if.sv
// rtl/divider_datapath_if.sv - control-word, operand and result signals between control unit and datapath.
// Optional dz status is present only when DIV_ZERO_DETECT_EN is defined.
interface divider_datapath_if;
  import div_pkg::*;

  logic             c0;
  logic             c1;
  logic             c2;
  logic             c3;
  logic             c4;
  logic             c5;
  logic             c6;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             s;
  logic             count31;
  logic [WIDTH-1:0] outbus;
`ifdef DIV_ZERO_DETECT_EN
  logic             dz;
`endif

  modport master (
    output c0, c1, c2, c3, c4, c5, c6, dividend, divisor,
`ifdef DIV_ZERO_DETECT_EN
    input  dz,
`endif
    input  s, count31, outbus
  );

  modport slave (
    input  c0, c1, c2, c3, c4, c5, c6, dividend, divisor,
`ifdef DIV_ZERO_DETECT_EN
    output dz,
`endif
    output s, count31, outbus
  );
endinterface

// File: rtl/div_addsub.sv
// rtl/div_addsub.sv - combinational modulo-2^W adder/subtractor for the partial remainder.
module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);
  assign sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - unsigned non-restoring division datapath driven by strobes c0..c6.
// Define DIV_ZERO_DETECT_EN to add the sticky divide-by-zero flag and dz port.
module divider_datapath
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_b,
  divider_datapath_if.slave bus
);

  logic [AW-1:0]    a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out_reg;
  logic [AW-1:0]    addsub_sum;

`ifdef DIV_ZERO_DETECT_EN
  logic             dz_reg;
  logic [WIDTH-1:0] dvd_shadow;
`endif

  div_addsub #(.W(AW)) u_addsub (
    .a   (a_reg),
    .b   ({1'b0, m_reg}),
    .sub (bus.c3),
    .sum (addsub_sum)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      cnt     <= '0;
      out_reg <= '0;
    end else if (bus.c0) begin
      a_reg <= '0;
      q_reg <= bus.dividend;
      m_reg <= bus.divisor;
      cnt   <= '0;
    end else begin
      if (bus.c1) begin
        {a_reg, q_reg} <= {a_reg[WIDTH-1:0], q_reg, 1'b0};
      end else begin
        // c4 alongside c2 is the final correction: quotient bit uses the sign before the add
        if (bus.c2) a_reg    <= addsub_sum;
        if (bus.c4) q_reg[0] <= ~a_reg[WIDTH];
      end
      if (bus.c4) cnt <= cnt + 1'b1;

`ifdef DIV_ZERO_DETECT_EN
      if (bus.c6)      out_reg <= dz_reg ? {WIDTH{1'b1}} : q_reg;
      else if (bus.c5) out_reg <= dz_reg ? dvd_shadow : a_reg[WIDTH-1:0];
`else
      if (bus.c6)      out_reg <= q_reg;
      else if (bus.c5) out_reg <= a_reg[WIDTH-1:0];
`endif
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dz_reg     <= 1'b0;
      dvd_shadow <= '0;
    end else if (bus.c0) begin
      dz_reg     <= (bus.divisor == '0);
      dvd_shadow <= bus.dividend;
    end
  end

  assign bus.dz = dz_reg;
`endif

  assign bus.s       = a_reg[WIDTH];
  assign bus.count31 = (cnt == CNT_W'(WIDTH - 1));
  assign bus.outbus  = out_reg;

endmodule

// File: tb/tb_divider_datapath.sv
// tb/tb_divider_datapath.sv - directed self-checking bench with a result scoreboard for divider_datapath.
module tb_divider_datapath;
  import div_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  divider_datapath_if bus ();

  divider_datapath dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [NCTL-1:0] st);
    bus.c0 = st[LOAD];
    bus.c1 = st[SHIFT];
    bus.c2 = st[ADDSUB];
    bus.c3 = st[SUBSEL];
    bus.c4 = st[QSET];
    bus.c5 = st[OUT_R];
    bus.c6 = st[OUT_Q];
    @(posedge clk);
    #1;
    {bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6} = '0;
  endtask

  function automatic logic [NCTL-1:0] bitv(input int pos);
    logic [NCTL-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  // Plays the control unit: n_iter iterations, final correction folded into the last c4
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int n_iter,
                         input bit chk_cnt, output logic last_s);
    logic sp;
    logic [NCTL-1:0] v;
    bit last;
    last_s = 1'b0;
    bus.dividend = a;
    bus.divisor  = b;
    tick(bitv(LOAD));
    for (int i = 0; i < n_iter; i++) begin
      last = (i == WIDTH - 1);
      sp = bus.s;
      tick(bitv(SHIFT));
      v = bitv(ADDSUB);
      if (!sp) v[SUBSEL] = 1'b1;
      tick(v);
      if (chk_cnt && i >= WIDTH - 2) chk("count31_iter", {31'b0, bus.count31}, {31'b0, last});
      v = bitv(QSET);
      if (last) begin
        last_s = bus.s;
        if (bus.s) v[ADDSUB] = 1'b1;
      end
      tick(v);
    end
    if (chk_cnt) chk("count31_after", {31'b0, bus.count31}, 32'd0);
  endtask

  task automatic read_result(input string name, input logic [31:0] r, input logic [31:0] q);
    exp_t e;
    sb.push_back('{{name, "_rem"}, r});
    tick(bitv(OUT_R));
    e = sb.pop_front();
    chk(e.tag, bus.outbus, e.val);
    sb.push_back('{{name, "_quot"}, q});
    tick(bitv(OUT_Q));
    e = sb.pop_front();
    chk(e.tag, bus.outbus, e.val);
  endtask

  initial begin
    logic ls;
    logic [31:0] ra, rb;
    {bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6} = '0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2;
    chk("rst_outbus", bus.outbus, 32'd0);
    chk("rst_s", {31'b0, bus.s}, 32'd0);
    chk("rst_count31", {31'b0, bus.count31}, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    run_div(32'd100, 32'd7, 32, 1'b0, ls);
    read_result("100_7", 32'd2, 32'd14);

    run_div(32'd7, 32'd100, 32, 1'b0, ls);
    chk("7_100_last_s", {31'b0, ls}, 32'd1);
    read_result("7_100", 32'd7, 32'd0);

    run_div(32'hFFFF_FFFF, 32'd1, 32, 1'b1, ls);
    read_result("ffff_1", 32'd0, 32'hFFFF_FFFF);

    run_div(32'd37, 32'd37, 32, 1'b0, ls);
    read_result("37_37", 32'd0, 32'd1);
    run_div(32'd37, 32'd37, 5, 1'b0, ls);
    run_div(32'd10, 32'd3, 32, 1'b0, ls);
    read_result("restart_10_3", 32'd1, 32'd3);

    // Asynchronous reset mid-division, away from any clock edge
    run_div(32'd100, 32'd7, 12, 1'b0, ls);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_outbus", bus.outbus, 32'd0);
    chk("arst_s", {31'b0, bus.s}, 32'd0);
    chk("arst_count31", {31'b0, bus.count31}, 32'd0);
    chk("arst_a", dut.a_reg[31:0], 32'd0);
    chk("arst_q", dut.q_reg, 32'd0);
    chk("arst_m", dut.m_reg, 32'd0);
    chk("arst_cnt", {27'b0, dut.cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    run_div(32'd9, 32'd2, 32, 1'b0, ls);
    read_result("9_2", 32'd1, 32'd4);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = $urandom_range(32'h7FFF_FFFF, 1);
      run_div(ra, rb, 32, 1'b0, ls);
      read_result("rand", ra % rb, ra / rb);
    end

    // Divide by zero: algorithm and dz override both give R=dividend, Q=all-ones
    run_div(32'd55, 32'd0, 32, 1'b0, ls);
`ifdef DIV_ZERO_DETECT_EN
    chk("dz_set", {31'b0, bus.dz}, 32'd1);
`endif
    read_result("55_0", 32'd55, 32'hFFFF_FFFF);
    run_div(32'd55, 32'd5, 32, 1'b0, ls);
`ifdef DIV_ZERO_DETECT_EN
    chk("dz_clear", {31'b0, bus.dz}, 32'd0);
`endif
    read_result("55_5", 32'd0, 32'd11);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
